// File: rtl/smag_alu_arbiter.sv
// Round-robin arbiter that shares one sign-magnitude subtract datapath
// between NREQ requesters. Each accepted request takes IDLE -> EXEC -> RESP,
// and its result is held in RESP until the consumer takes it.
module smag_alu_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_op,
  input  logic [NREQ*N-1:0]         req_a,
  input  logic [NREQ*N-1:0]         req_b,
  output logic [N-1:0]              alu_a,
  output logic [N-1:0]              alu_b,
  input  logic [N-1:0]              alu_c,
  input  logic                      alu_zero,
  input  logic                      alu_neg,
  input  logic                      alu_cout,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [N-1:0]              rsp_c,
  output logic [2:0]                rsp_flags,
  output logic [15:0]               op_count
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [15:0]    a_reg, b_reg;
  logic           op_reg;
  logic [IDW-1:0] id_reg;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic           accept;

  // Requester index k positions after base, wrapping at NREQ.
  function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Operands are 16-bit sign-magnitude; the upper bits of each slice are ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, req_a, req_b};

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[rot_idx(rr_ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rot_idx(rr_ptr, k);
      end
    end
  end

  // One-hot ready only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign accept    = (state == IDLE) && gnt_any;
  assign rsp_valid = (state == RESP);

  // Next-state logic: EXEC always lasts one cycle, RESP waits for the consumer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand capture on accept; later req_* changes cannot disturb the operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= 1'b0;
      id_reg <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      a_reg  <= req_a[int'(gnt_idx)*N +: 16];
      b_reg  <= req_b[int'(gnt_idx)*N +: 16];
      op_reg <= req_op[gnt_idx];
      id_reg <= gnt_idx;
      rr_ptr <= rot_idx(gnt_idx, 1);
    end
  end

  // Datapath operands; for add, b's sign is flipped so a+b becomes a-(-b).
  always_comb begin
    alu_a        = '0;
    alu_b        = '0;
    alu_a[15:0]  = a_reg;
    alu_b[15:0]  = {b_reg[15] ^ op_reg, b_reg[14:0]};
  end

  // Result capture in EXEC; held unchanged through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_c     <= '0;
      rsp_flags <= '0;
      rsp_id    <= '0;
    end else if (state == EXEC) begin
      rsp_c     <= alu_c;
      rsp_flags <= {alu_cout, alu_neg, alu_zero};
      rsp_id    <= id_reg;
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              op_count <= '0;
    else if (state == RESP && rsp_ready)  op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_smag_alu_arbiter.sv
// Bench for smag_alu_arbiter: emulates the shared datapath, tracks expected
// behaviour with a transaction-level model and checks outputs every cycle.
module tb_smag_alu_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_op = '0;
  logic [NREQ*N-1:0]    req_a = '0;
  logic [NREQ*N-1:0]    req_b = '0;
  logic [N-1:0]         alu_a, alu_b, alu_c;
  logic                 alu_zero, alu_neg, alu_cout;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [1:0]           rsp_id;
  logic [N-1:0]         rsp_c;
  logic [2:0]           rsp_flags;
  logic [15:0]          op_count;

  int total = 0;
  int bad   = 0;

  smag_alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_flags(rsp_flags), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Signed value of a 16-bit sign-magnitude word.
  function automatic int sm_val(input logic [15:0] x);
    return x[15] ? -int'({17'b0, x[14:0]}) : int'({17'b0, x[14:0]});
  endfunction

  // Sign-magnitude encoding of an integer result: {cout, neg, zero, c[31:0]}.
  function automatic logic [34:0] sm_pack(input int r);
    int   mag, m15;
    logic cout, neg, zero;
    mag  = (r < 0) ? -r : r;
    cout = (mag > 32767);
    m15  = mag % 32768;
    zero = (m15 == 0);
    neg  = (r < 0);
    return {cout, neg, zero, 16'h0, neg, m15[14:0]};
  endfunction

  // Shared subtract datapath: c = a - b in sign-magnitude.
  always_comb
    {alu_cout, alu_neg, alu_zero, alu_c} = sm_pack(sm_val(alu_a[15:0]) - sm_val(alu_b[15:0]));

  // ---------------- behavioural model ----------------
  typedef struct {
    int          id;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
  } txn_t;

  bit   m_busy = 0;
  int   m_age  = 0;   // cycles since acceptance: 1 = executing, 2 = result offered
  txn_t m_t;
  int   m_rr   = 0;
  int   m_cnt  = 0;

  function automatic int pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++)
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_busy = 0; m_age = 0; m_rr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      g = pick(req_valid, m_rr);
      if (g >= 0) begin
        m_t.id = g;
        m_t.op = req_op[g];
        m_t.a  = req_a[g*N +: 16];
        m_t.b  = req_b[g*N +: 16];
        m_busy = 1; m_age = 1;
        m_rr   = (g + 1) % NREQ;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (rsp_ready) begin
      m_busy = 0; m_age = 0;
      m_cnt  = (m_cnt + 1) % 65536;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] e_rdy;
    logic [34:0]     e_res;
    int              g, r;
    if (rst) begin
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_valid", 64'(rsp_valid), 64'd0);
      check("rst_count", 64'(op_count), 64'd0);
      check("rst_c", 64'(rsp_c), 64'd0);
      check("rst_flags", 64'(rsp_flags), 64'd0);
      check("rst_id", 64'(rsp_id), 64'd0);
    end else begin
      e_rdy = '0;
      g = pick(req_valid, m_rr);
      if (!m_busy && g >= 0) e_rdy[g] = 1'b1;
      check("m_ready", 64'(req_ready), 64'(e_rdy));
      check("m_valid", 64'(rsp_valid), 64'(m_busy && m_age == 2));
      check("m_count", 64'(op_count), 64'(m_cnt));
      if (m_busy && m_age == 1) begin
        check("m_alu_a", 64'(alu_a), 64'({16'h0, m_t.a}));
        check("m_alu_b", 64'(alu_b), 64'({16'h0, m_t.b[15] ^ m_t.op, m_t.b[14:0]}));
      end
      if (m_busy && m_age == 2) begin
        r = m_t.op ? sm_val(m_t.a) + sm_val(m_t.b) : sm_val(m_t.a) - sm_val(m_t.b);
        e_res = sm_pack(r);
        check("m_rsp_c", 64'(rsp_c), 64'(e_res[31:0]));
        check("m_flags", 64'(rsp_flags), 64'(e_res[34:32]));
        check("m_id", 64'(rsp_id), 64'(m_t.id));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic single_op(input string tag, input int id, input logic op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp_c, input logic [2:0] exp_f,
                           input logic [31:0] exp_alub);
    bit got;
    @(posedge clk); #1;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    req_a[id*N +: N] = {16'h0, a};
    req_b[id*N +: N] = {16'h0, b};
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
    end
    check({tag, "_grant"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    req_op    = NREQ'($urandom);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = $urandom;
      req_b[i*N +: N] = $urandom;
    end
    @(negedge clk);
    check({tag, "_exec_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_alu_b"}, 64'(alu_b), 64'(exp_alub));
    @(negedge clk);
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_c"}, 64'(rsp_c), 64'(exp_c));
    check({tag, "_flags"}, 64'(rsp_flags), 64'(exp_f));
    check({tag, "_id"}, 64'(rsp_id), 64'(id));
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int gidx;
    bit seen;

    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    rsp_ready = 1'b1;

    single_op("sub_pos", 0, 1'b0, 16'h0005, 16'h0003, 32'h0000_0002, 3'b000, 32'h0000_0003);
    single_op("sub_neg", 1, 1'b0, 16'h0003, 16'h0005, 32'h0000_8002, 3'b010, 32'h0000_0005);
    single_op("add_mix", 2, 1'b1, 16'h0005, 16'h8003, 32'h0000_0002, 3'b000, 32'h0000_0003);
    single_op("sub_zero", 3, 1'b0, 16'h0007, 16'h0007, 32'h0000_0000, 3'b001, 32'h0000_0007);

    // All requesters valid: fair rotation 0,1,2,3,0.
    @(posedge clk); #1;
    req_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 32'h10 + 32'(i);
      req_b[i*N +: N] = 32'h1;
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      seen = 0; gidx = -1;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          seen = 1;
          for (int i = 0; i < NREQ; i++) if (req_ready[i]) gidx = i;
        end
      end
      check($sformatf("order_%0d", k), 64'(gidx), 64'(exp_order[k]));
      @(posedge clk);
    end
    #1 rsp_ready = 1'b0;

    // Response held while the consumer stalls.
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("hold_seen", 64'(seen), 64'd1);
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_id", 64'(rsp_id), 64'd0);
      check("hold_c", 64'(rsp_c), 64'h0F);
      check("hold_count", 64'(op_count), 64'd8);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    // Reset while a response is pending.
    #1 rsp_ready = 1'b0;
    req_valid = 4'b0100;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (req_ready[2]) seen = 1;
    end
    check("rst_grant", 64'(seen), 64'd1);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 4'b1010;
    @(negedge clk);
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_count", 64'(op_count), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", 64'(req_ready), 64'b0010);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom);
      req_op    = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*N +: N] = $urandom;
        req_b[i*N +: N] = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
